// File: rtl/dff_n_mode_pkg.sv
// Shared op encoding for the multi-mode register.
package dff_n_mode_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_HOLD = 3'b000;
    localparam op_t OP_LOAD = 3'b001;
    localparam op_t OP_INC  = 3'b010;
    localparam op_t OP_DEC  = 3'b011;
    localparam op_t OP_SHL  = 3'b100;
    localparam op_t OP_SHR  = 3'b101;
    localparam op_t OP_ROL  = 3'b110;
    localparam op_t OP_CLR  = 3'b111;

endpackage

// File: rtl/dff_n_mode_next.sv
// Next-state function of the multi-mode register: pure combinational.
// Build option: DFF_N_MODE_SATURATE_EN makes INC/DEC saturate instead of wrap.
module dff_n_mode_next
    import dff_n_mode_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  op_t              op,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    input  logic             si,
    output logic [WIDTH-1:0] next_q,
    output logic             next_co
);

    // One-wider operand so the carry/borrow drops out of the top bit.
    localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH:0] inc_sum;
    logic [WIDTH:0] dec_dif;

    assign inc_sum = {1'b0, q} + ONE;
    assign dec_dif = {1'b0, q} - ONE;

    // Select the op result; HOLD/LOAD/CLR never produce a carry.
    always_comb begin
        next_q  = q;
        next_co = 1'b0;
        unique case (op)
            OP_HOLD: next_q = q;
            OP_LOAD: next_q = d;
            OP_INC: begin
                {next_co, next_q} = inc_sum;
`ifdef DFF_N_MODE_SATURATE_EN
                if (&q) next_q = q;
`endif
            end
            OP_DEC: begin
                {next_co, next_q} = dec_dif;
`ifdef DFF_N_MODE_SATURATE_EN
                if (q == '0) next_q = '0;
`endif
            end
            OP_SHL: begin
                next_q  = {q[WIDTH-2:0], si};
                next_co = q[WIDTH-1];
            end
            OP_SHR: begin
                next_q  = {si, q[WIDTH-1:1]};
                next_co = q[0];
            end
            OP_ROL: begin
                next_q  = {q[WIDTH-2:0], q[WIDTH-1]};
                next_co = q[WIDTH-1];
            end
            OP_CLR: next_q = '0;
            default: next_q = q;
        endcase
    end

endmodule

// File: rtl/dff_n_mode_r.sv
// Parametrised multi-mode register (hold/load/inc/dec/shift/rotate/clear)
// with registered zero, carry-out and counter-running flags.
// Build option: DFF_N_MODE_SATURATE_EN (handled in dff_n_mode_next).
module dff_n_mode_r
    import dff_n_mode_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  op_t              op,
    input  logic [WIDTH-1:0] d,
    input  logic             si,
    output logic [WIDTH-1:0] q,
    output logic             zero,
    output logic             co,
    output logic             busy_dn
);

    logic [WIDTH-1:0] next_q;
    logic             next_co;
    logic             next_busy;

    dff_n_mode_next #(.WIDTH(WIDTH)) u_next (
        .op      (op),
        .q       (q),
        .d       (d),
        .si      (si),
        .next_q  (next_q),
        .next_co (next_co)
    );

    // busy_dn tracks a running down-counter; only DEC, LOAD and CLR touch it.
    // A saturated DEC yields next_q == 0, so it clears naturally.
    always_comb begin
        next_busy = busy_dn;
        if (op == OP_DEC)
            next_busy = |next_q;
        else if (op == OP_LOAD || op == OP_CLR)
            next_busy = 1'b0;
    end

    // State flops; zero is derived from next_q so it lands with q.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q       <= RESET_VAL;
            zero    <= (RESET_VAL == '0);
            co      <= 1'b0;
            busy_dn <= 1'b0;
        end else if (en) begin
            q       <= next_q;
            zero    <= (next_q == '0);
            co      <= next_co;
            busy_dn <= next_busy;
        end
    end

endmodule

// File: tb/tb_dff_n_mode_r.sv
// Bench for dff_n_mode_r: hand-derived vector table on a 4-bit instance
// with RESET_VAL=5, async reset corner, and a width sweep (2/8/32) against
// an independent reference model, all through an expected-value queue.
module tb_dff_n_mode_r;
    import dff_n_mode_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, sw_rst_n, en, si;
    op_t         op;
    logic [3:0]  d4;
    logic [1:0]  d2;
    logic [7:0]  d8;
    logic [31:0] d32;

    logic [3:0]  q4;
    logic [1:0]  q2;
    logic [7:0]  q8;
    logic [31:0] q32;
    logic z4, co4, b4, z2, co2, b2, z8, co8, b8, z32, co32, b32;

    dff_n_mode_r #(.WIDTH(4), .RESET_VAL(4'h5)) dut4 (
        .clk(clk), .reset_n(reset_n), .en(en), .op(op), .d(d4), .si(si),
        .q(q4), .zero(z4), .co(co4), .busy_dn(b4));
    dff_n_mode_r #(.WIDTH(2)) dut2 (
        .clk(clk), .reset_n(sw_rst_n), .en(en), .op(op), .d(d2), .si(si),
        .q(q2), .zero(z2), .co(co2), .busy_dn(b2));
    dff_n_mode_r #(.WIDTH(8)) dut8 (
        .clk(clk), .reset_n(sw_rst_n), .en(en), .op(op), .d(d8), .si(si),
        .q(q8), .zero(z8), .co(co8), .busy_dn(b8));
    dff_n_mode_r #(.WIDTH(32)) dut32 (
        .clk(clk), .reset_n(sw_rst_n), .en(en), .op(op), .d(d32), .si(si),
        .q(q32), .zero(z32), .co(co32), .busy_dn(b32));

    typedef struct {
        logic       en;
        op_t        op;
        logic [3:0] d;
        logic       si;
        logic [3:0] q;
        logic       z;
        logic       co;
        logic       b;
    } vec_t;

    typedef struct {
        int          unit;
        logic [63:0] q;
        logic        z;
        logic        co;
        logic        b;
    } exp_t;

    vec_t tbl[$];
    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    // unit 0 = 4-bit main, 1 = 2-bit, 2 = 8-bit, 3 = 32-bit
    int          wid[4] = '{4, 2, 8, 32};
    logic [63:0] mq[4];
    logic        mz[4], mco[4], mb[4];

    task automatic sample(input int u, output logic [63:0] aq,
                          output logic az, output logic aco, output logic ab);
        case (u)
            0: begin aq = 64'(q4);  az = z4;  aco = co4;  ab = b4;  end
            1: begin aq = 64'(q2);  az = z2;  aco = co2;  ab = b2;  end
            2: begin aq = 64'(q8);  az = z8;  aco = co8;  ab = b8;  end
            default: begin aq = 64'(q32); az = z32; aco = co32; ab = b32; end
        endcase
    endtask

    task automatic check_exp(input string nm, input exp_t e);
        logic [63:0] aq;
        logic az, aco, ab;
        sample(e.unit, aq, az, aco, ab);
        checks++;
        if ({aq, az, aco, ab} !== {e.q, e.z, e.co, e.b}) begin
            errors++;
            $display("FAIL %s unit%0d: got q=%h z=%b co=%b busy=%b, want q=%h z=%b co=%b busy=%b",
                     nm, e.unit, aq, az, aco, ab, e.q, e.z, e.co, e.b);
        end
    endtask

    task automatic pop_check(input string nm);
        exp_t e;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            e = sbq.pop_front();
            check_exp(nm, e);
        end
    endtask

    // Reference model, written from the op table with plain 64-bit arithmetic.
    task automatic model(input int u, input logic e, input op_t o,
                         input logic [63:0] dd, input logic s);
        int          w;
        logic [63:0] m, q0, nq;
        logic        nc;
        w  = wid[u];
        m  = (64'd1 << w) - 64'd1;
        q0 = mq[u];
        nq = q0;
        nc = 1'b0;
        if (!e) return;
        case (o)
            OP_LOAD: nq = dd & m;
            OP_INC: begin
                if (q0 == m) begin
                    nc = 1'b1;
`ifdef DFF_N_MODE_SATURATE_EN
                    nq = m;
`else
                    nq = 64'd0;
`endif
                end else nq = q0 + 64'd1;
            end
            OP_DEC: begin
                if (q0 == 64'd0) begin
                    nc = 1'b1;
`ifdef DFF_N_MODE_SATURATE_EN
                    nq = 64'd0;
`else
                    nq = m;
`endif
                end else nq = q0 - 64'd1;
            end
            OP_SHL: begin nc = q0[w-1]; nq = ((q0 << 1) | 64'(s)) & m; end
            OP_SHR: begin nc = q0[0];   nq = (q0 >> 1) | (64'(s) << (w-1)); end
            OP_ROL: begin nc = q0[w-1]; nq = ((q0 << 1) | (q0 >> (w-1))) & m; end
            OP_CLR: nq = 64'd0;
            default: nq = q0;
        endcase
        if (o == OP_DEC) mb[u] = (nq != 64'd0);
        else if (o == OP_LOAD || o == OP_CLR) mb[u] = 1'b0;
        mq[u]  = nq;
        mco[u] = nc;
        mz[u]  = (nq == 64'd0);
    endtask

    // Drive the sweep instances one cycle and check all three.
    task automatic sweep_step(input logic e, input op_t o, input logic s,
                              input logic [31:0] dv, input string nm);
        @(negedge clk);
        en = e; op = o; si = s;
        d2 = dv[1:0]; d8 = dv[7:0]; d32 = dv;
        for (int u = 1; u < 4; u++) begin
            model(u, e, o, 64'(dv), s);
            sbq.push_back('{u, mq[u], mz[u], mco[u], mb[u]});
        end
        @(posedge clk);
        #1;
        for (int u = 1; u < 4; u++) pop_check(nm);
    endtask

    initial begin
        exp_t e;
        vec_t v;
        logic [31:0] rv;

        // rows: en, op, d, si, expected q, zero, co, busy
        tbl.push_back('{1'b1, OP_LOAD, 4'h3, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, OP_DEC,  4'h0, 1'b0, 4'h2, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b1, OP_DEC,  4'h0, 1'b0, 4'h1, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b1, OP_DEC,  4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0});
`ifdef DFF_N_MODE_SATURATE_EN
        tbl.push_back('{1'b1, OP_DEC,  4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{1'b1, OP_LOAD, 4'hF, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, OP_INC,  4'h0, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0});
`else
        tbl.push_back('{1'b1, OP_DEC,  4'h0, 1'b0, 4'hF, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{1'b1, OP_LOAD, 4'hF, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, OP_INC,  4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0});
`endif
        tbl.push_back('{1'b1, OP_LOAD, 4'h9, 1'b0, 4'h9, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, OP_SHL,  4'h0, 1'b0, 4'h2, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{1'b1, OP_HOLD, 4'h0, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, OP_LOAD, 4'h9, 1'b0, 4'h9, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, OP_SHR,  4'h0, 1'b1, 4'hC, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{1'b1, OP_LOAD, 4'h9, 1'b0, 4'h9, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, OP_ROL,  4'h0, 1'b0, 4'h3, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{1'b1, OP_LOAD, 4'h5, 1'b0, 4'h5, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, OP_DEC,  4'h0, 1'b0, 4'h4, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b1, OP_INC,  4'h0, 1'b0, 4'h5, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b1, OP_SHL,  4'h0, 1'b0, 4'hA, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b1, OP_SHR,  4'h0, 1'b0, 4'h5, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b1, OP_CLR,  4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, OP_LOAD, 4'h2, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, OP_DEC,  4'h0, 1'b0, 4'h1, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b1, OP_LOAD, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, OP_LOAD, 4'hB, 1'b0, 4'hB, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, OP_ROL,  4'h0, 1'b0, 4'h7, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{1'b0, OP_CLR,  4'h0, 1'b0, 4'h7, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{1'b0, OP_CLR,  4'h0, 1'b0, 4'h7, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{1'b0, OP_CLR,  4'h0, 1'b0, 4'h7, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{1'b1, OP_CLR,  4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, OP_LOAD, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0});

        reset_n = 1'b0; sw_rst_n = 1'b0;
        en = 1'b0; op = OP_HOLD; si = 1'b0;
        d4 = '0; d2 = '0; d8 = '0; d32 = '0;
        repeat (2) @(posedge clk);
        #1;
        check_exp("reset_state", '{0, 64'h5, 1'b0, 1'b0, 1'b0});

        @(negedge clk);
        reset_n = 1'b1;

        // Vector table on the 4-bit instance.
        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            @(negedge clk);
            en = v.en; op = v.op; d4 = v.d; si = v.si;
            sbq.push_back('{0, 64'(v.q), v.z, v.co, v.b});
            @(posedge clk);
            #1;
            pop_check($sformatf("vec%0d", i));
        end

        // Async reset in the middle of an INC run: q=0 -> INC -> 1, then reset.
        @(negedge clk);
        en = 1'b1; op = OP_INC;
        @(posedge clk);
        #1;
        check_exp("inc_before_reset", '{0, 64'h1, 1'b0, 1'b0, 1'b0});
        #2;
        reset_n = 1'b0;
        #1;
        check_exp("async_reset_immediate", '{0, 64'h5, 1'b0, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        check_exp("reset_held", '{0, 64'h5, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        reset_n = 1'b1;
        en = 1'b0;

        // Width sweep on WIDTH = 2 / 8 / 32.
        for (int u = 1; u < 4; u++) begin
            mq[u] = 64'd0; mz[u] = 1'b1; mco[u] = 1'b0; mb[u] = 1'b0;
            e = '{u, 64'd0, 1'b1, 1'b0, 1'b0};
            check_exp("sweep_reset", e);
        end
        @(negedge clk);
        sw_rst_n = 1'b1;

        sweep_step(1'b1, OP_LOAD, 1'b0, 32'hFFFF_FFFF, "sweep_load_ones");
        sweep_step(1'b1, OP_INC,  1'b0, 32'h0,         "sweep_inc_wrap");
        sweep_step(1'b1, OP_DEC,  1'b0, 32'h0,         "sweep_dec_wrap");

        for (int i = 0; i < 10000; i++) begin
            rv = $urandom;
            case ($urandom_range(0, 7))
                0: rv = 32'hFFFF_FFFF;
                1: rv = 32'h0;
                2: rv = 32'h1;
                default: ;
            endcase
            sweep_step($urandom_range(0, 7) != 0, op_t'($urandom_range(0, 7)),
                       1'($urandom_range(0, 1)), rv, "sweep_rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
